// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle subtractor computing diff = a - b - bin over N bits,
// W bits per clock through a registered borrow chain (N/W cycles per result).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set offered
//   in_ready   block can accept operands (high only when idle)
//   a, b, bin  minuend, subtrahend, borrow in (sampled only at acceptance)
//   out_valid  result available
//   out_ready  consumer accepts result
//   diff       (a - b - bin) mod 2^N, registered, held until next completion
//   bout       unsigned borrow out (a < b + bin)
//   ovf        signed overflow (borrow into MSB xor borrow out of MSB)
module serial_subtractor #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned NumDigits = N / W;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [W-1:0]    dig;
    logic            dig_bout;
    logic            dig_bmsb;
    logic [N-1:0]    dig_ext;

    // Bit-level borrow ripple across the current low digit of the operand shifters.
    // dig_bmsb is the borrow entering the digit's top bit; on the last digit that is
    // the borrow into bit N-1 needed for signed overflow.
    always_comb begin
        logic br;
        br       = borrow_q;
        dig      = '0;
        dig_bmsb = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (i == int'(W) - 1) begin
                dig_bmsb = br;
            end
            dig[i] = a_q[i] ^ b_q[i] ^ br;
            br     = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
        end
        dig_bout = br;
    end

    // New digit enters the result shifter from the MSB side.
    always_comb begin
        dig_ext            = '0;
        dig_ext[N-1 -: W]  = dig;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                a_d      = a_q >> W;
                b_d      = b_q >> W;
                res_d    = (res_q >> W) | dig_ext;
                borrow_d = dig_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    diff_d  = (res_q >> W) | dig_ext;
                    bout_d  = dig_bout;
                    ovf_d   = dig_bmsb ^ dig_bout;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle unsigned/two's-complement subtractor computing `diff = a - b - bin` over N bits. It processes W bits per clock through a registered borrow chain, so a full result takes N/W cycles. Operands enter through a valid/ready handshake and results leave through another. It is the subtracting, sequential counterpart of the team's combinational adders. It sits in datapaths where area matters more than latency, such as a serial ALU or a comparator stage.

## Interface
Parameters:
- `N`, 16, operand/result width; must be a multiple of `W`
- `W`, 4, bits processed per cycle (digit width); 1 ≤ W ≤ N

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `in_valid`  in  1  operand set offered
- `in_ready`  out  1  block can accept operands (high only in IDLE)
- `a`  in  N  minuend
- `b`  in  N  subtrahend
- `bin`  in  1  borrow in
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `diff`  out  N  (a - b - bin) mod 2^N
- `bout`  out  1  borrow out: 1 iff a < b + bin (unsigned)
- `ovf`  out  1  signed overflow = borrow into bit N-1 XOR borrow out of bit N-1

## Operation
- Clock `clk`, single domain. Reset `rst_n` is asynchronous and active-low.
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `a`, `b` and `bin` into internal shift registers. Load the borrow flop with `bin`, clear the digit counter and go to BUSY.
- Inputs are sampled only at acceptance. Later changes on `a`, `b` and `bin` have no effect on the result.
- BUSY: each cycle computes one W-bit digit, LSB digit first.
  - Digit computation: `{borrow', d} = a_digit - b_digit - borrow`.
  - Shift `d` into the result register from the MSB side. Store `borrow'` in the borrow flop.
  - Increment the counter.
  - When processing the final digit (counter = N/W-1), also record borrow-into-MSB, taken from bit N-1 of that digit's internal chain. Then go to DONE.
- DONE: `out_valid`=1. `diff`, `bout` and `ovf` are stable and held.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_valid` is ignored in BUSY and DONE.
- Outputs `diff`, `bout` and `ovf` are registered. They retain the last result after leaving DONE and update only when the next operation completes.
- Special case W = N: BUSY lasts exactly one cycle.
- The digit counter width is ceil(log2(N/W)), with a minimum of 1 bit.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1
  - `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0
  - internal shift registers, counter and borrow flop all 0
- Reset asserted mid-BUSY or mid-DONE: the block immediately returns to IDLE with the values above. The in-flight result is discarded and no `out_valid` pulse is produced.
- Latency, with acceptance at edge k:
  - BUSY covers edges k+1 … k+N/W.
  - `out_valid` goes high after edge k+N/W.
  - Defaults (N=16, W=4): 4 cycles.
- `in_ready` drops the cycle after acceptance.
- Throughput: with `out_ready` tied high, one result per N/W+2 cycles:
  - DONE lasts one cycle.
  - IDLE lasts one cycle before the next acceptance.
  - No accept occurs in the same cycle as the result handoff.
- Back-pressure: while `out_ready`=0 in DONE, `out_valid`, `diff`, `bout` and `ovf` stay constant and `in_ready` stays 0.
- `out_valid` falls the cycle after the handshake, and `in_ready` rises in that same cycle.

## Test plan
With N=16, W=4:
- a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0; `out_valid` exactly 4 cycles after acceptance.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Also a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1, ovf=0.
- Signed overflow, covering both the overflow and no-overflow boundary:
  - a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1.
  - a=0x8000, b=0x0000, bin=1 → diff=0x7FFF, bout=0, ovf=1.
  - a=0x0000, b=0x7FFF, bin=1 → diff=0x8000, bout=1, ovf=0.
- Back-pressure:
  - Hold `out_ready`=0 for 3 cycles in DONE while toggling `a`, `b` and `in_valid`: outputs unchanged, `in_ready`=0, no new acceptance.
  - Raise `out_ready`: `out_valid` drops and `in_ready` rises next cycle.
- Reset mid-BUSY: assert `rst_n`=0 after 2 digits. Every output takes its reset value asynchronously and `in_ready`=1 after release. The next operation, a=0xFFFF, b=0x0001 → diff=0xFFFE, bout=0, is correct.
- Back-to-back random: 1000 random a/b/bin with random `in_valid` and `out_ready`. Results match the reference model a-b-bin, and no operation is dropped or duplicated. Repeat with W=1 (16 cycles) and W=16 (1 cycle).
